uart_word_assembler: RTL and testbench

UART_WORD_ASSEMBLER -- requirements
Module: uart_word_assembler

---
 rtl/uart_word_assembler.sv | 173 +++++++++++++++++
 tb/tb_uart_word_assembler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_assembler.sv
// Purpose : packs four UART bytes (little-endian) into a 32-bit word and queues it in a 2-deep FIFO.
// Latency : a word is visible on o_Word/o_Word_Valid one cycle after the strobe of its 4th byte.
// Backpres: o_Word_Valid/i_Word_Ready handshake; a word completed while the FIFO is full is dropped (o_Overflow).
//
// Ports:
//   i_Clock, i_Rst          rising-edge clock, asynchronous active-high reset
//   i_RX_DV, i_RX_Byte      one-cycle byte strobe and data from the UART receiver
//   o_Word_Valid, o_Word    FIFO head word (fp32 bit pattern), 32'h0 while the FIFO is empty
//   i_Word_Ready            consumer accepts the head word this cycle
//   o_Overflow, i_Clear_Err sticky drop flag and its clear (a same-cycle drop beats the clear)
//   o_Timeout               one-cycle pulse when a partial word is abandoned after TIMEOUT_CLKS idle clocks
module uart_word_assembler #(
    parameter int TIMEOUT_CLKS = 2170
) (
    input  logic        i_Clock,
    input  logic        i_Rst,
    input  logic        i_RX_DV,
    input  logic [7:0]  i_RX_Byte,
    output logic        o_Word_Valid,
    output logic [31:0] o_Word,
    input  logic        i_Word_Ready,
    output logic        o_Overflow,
    output logic        o_Timeout,
    input  logic        i_Clear_Err
);

    localparam int            CW        = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] C_CNT_MAX = CW'(TIMEOUT_CLKS - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // assembler state
    state_t        r_state;
    state_t        w_state_next;
    logic [1:0]    r_idx;
    logic [1:0]    w_idx_next;
    logic [CW-1:0] r_idle_cnt;
    logic [CW-1:0] w_idle_cnt_next;
    logic [23:0]   r_bytes;        // b2,b1,b0 held while collecting
    logic          w_expire;
    logic          w_push;
    logic [31:0]   w_word;

    // output FIFO
    logic [31:0]   r_mem [0:1];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;
    logic          w_pop;
    logic          w_push_ok;
    logic          r_overflow;
    logic          r_timeout;

    // ------------------------------------------------------------------
    // Assembler FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            r_state    <= IDLE;
            r_idx      <= 2'd0;
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_idle_cnt <= w_idle_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_idle_cnt_next = r_idle_cnt;
        w_expire        = 1'b0;
        w_push          = 1'b0;
        case (r_state)
            IDLE: begin
                w_idle_cnt_next = '0;
                if (i_RX_DV) begin
                    w_state_next = COLLECT;
                    w_idx_next   = 2'd1;
                end
            end
            COLLECT: begin
                // A byte in the expiry cycle wins: it is taken and the counter restarts.
                if (i_RX_DV) begin
                    w_idle_cnt_next = '0;
                    if (r_idx == 2'd3) begin
                        w_push       = 1'b1;
                        w_state_next = IDLE;
                        w_idx_next   = 2'd0;
                    end else begin
                        w_idx_next = r_idx + 2'd1;
                    end
                end else if (r_idle_cnt == C_CNT_MAX) begin
                    w_expire        = 1'b1;
                    w_state_next    = IDLE;
                    w_idx_next      = 2'd0;
                    w_idle_cnt_next = '0;
                end else begin
                    w_idle_cnt_next = r_idle_cnt + CW'(1);
                end
            end
            default: begin
                w_state_next    = IDLE;
                w_idx_next      = 2'd0;
                w_idle_cnt_next = '0;
            end
        endcase
    end

    // Byte holding register; the 4th byte goes straight into the FIFO.
    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            r_bytes <= '0;
        end else if (i_RX_DV) begin
            case (r_idx)
                2'd0:    r_bytes[7:0]   <= i_RX_Byte;
                2'd1:    r_bytes[15:8]  <= i_RX_Byte;
                2'd2:    r_bytes[23:16] <= i_RX_Byte;
                default: r_bytes        <= r_bytes;
            endcase
        end
    end

    assign w_word = {i_RX_Byte, r_bytes};

    // ------------------------------------------------------------------
    // 2-entry output FIFO
    // ------------------------------------------------------------------
    assign w_pop     = (r_count != 2'd0) && i_Word_Ready;
    // Occupancy is judged after a same-cycle pop, so a full FIFO being read still accepts.
    assign w_push_ok = w_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge i_Clock) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= 2'd0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count   <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop};
            r_timeout <= w_expire;
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end else if (i_Clear_Err) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Gate the head with occupancy so never-written storage is not exposed.
    assign o_Word_Valid = (r_count != 2'd0);
    assign o_Word       = o_Word_Valid ? r_mem[r_rptr] : 32'h0;
    assign o_Overflow   = r_overflow;
    assign o_Timeout    = r_timeout;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Purpose : directed test of uart_word_assembler (table of single-cycle vectors plus multi-cycle sequences).
// Latency : inputs are applied #1 after a rising edge, outputs are checked #1 after the next one.
// Backpres: exercises ready low/high, full-FIFO overflow and simultaneous push/pop.
module tb_uart_word_assembler;

    logic        clk;
    logic        rst;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        word_vld;
    logic [31:0] word_dat;
    logic        word_rdy;
    logic        ovf;
    logic        tmo;
    logic        clr;

    int n_checks = 0;
    int n_errors = 0;

    uart_word_assembler #(.TIMEOUT_CLKS(20)) dut (
        .i_Clock      (clk),
        .i_Rst        (rst),
        .i_RX_DV      (rx_dv),
        .i_RX_Byte    (rx_byte),
        .o_Word_Valid (word_vld),
        .o_Word       (word_dat),
        .i_Word_Ready (word_rdy),
        .o_Overflow   (ovf),
        .o_Timeout    (tmo),
        .i_Clear_Err  (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [7:0]  b;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [31:0] ew;
        logic        eovf;
        logic [1:0]  ecnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic dv, input logic [7:0] b, input logic rdy, input logic cl,
                       input logic ev, input logic [31:0] ew, input logic eovf, input logic [1:0] ecnt);
        vec_t v;
        v.dv = dv; v.b = b; v.rdy = rdy; v.clr = cl;
        v.ev = ev; v.ew = ew; v.eovf = eovf; v.ecnt = ecnt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        tick();
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    int to_cnt;

    initial begin
        rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; word_rdy = 1'b0; clr = 1'b0;

        // pi word, then ready-while-empty and ignored data with DV low
        add(1, 8'hDB, 1, 0, 0, 32'h0,        0, 2'd0);
        add(1, 8'h0F, 1, 0, 0, 32'h0,        0, 2'd0);
        add(1, 8'h49, 1, 0, 0, 32'h0,        0, 2'd0);
        add(1, 8'h40, 1, 0, 1, 32'h40490FDB, 0, 2'd1);
        add(0, 8'h00, 1, 0, 0, 32'h0,        0, 2'd0);
        add(0, 8'h00, 1, 0, 0, 32'h0,        0, 2'd0);
        add(0, 8'hFF, 0, 0, 0, 32'h0,        0, 2'd0);
        // backpressure: three words with ready low
        add(1, 8'h00, 0, 0, 0, 32'h0,        0, 2'd0);
        add(1, 8'h00, 0, 0, 0, 32'h0,        0, 2'd0);
        add(1, 8'h80, 0, 0, 0, 32'h0,        0, 2'd0);
        add(1, 8'h3F, 0, 0, 1, 32'h3F800000, 0, 2'd1);
        add(0, 8'h00, 0, 0, 1, 32'h3F800000, 0, 2'd1);
        add(1, 8'h00, 0, 0, 1, 32'h3F800000, 0, 2'd1);
        add(1, 8'h00, 0, 0, 1, 32'h3F800000, 0, 2'd1);
        add(1, 8'h00, 0, 0, 1, 32'h3F800000, 0, 2'd1);
        add(1, 8'h40, 0, 0, 1, 32'h3F800000, 0, 2'd2);
        add(1, 8'h00, 0, 0, 1, 32'h3F800000, 0, 2'd2);
        add(1, 8'h00, 0, 0, 1, 32'h3F800000, 0, 2'd2);
        add(1, 8'h40, 0, 0, 1, 32'h3F800000, 0, 2'd2);
        // dropped word with a simultaneous clear: set wins
        add(1, 8'h40, 0, 1, 1, 32'h3F800000, 1, 2'd2);
        add(0, 8'h00, 0, 0, 1, 32'h3F800000, 1, 2'd2);
        // drain, then clear the sticky flag
        add(0, 8'h00, 1, 0, 1, 32'h40000000, 1, 2'd1);
        add(0, 8'h00, 1, 0, 0, 32'h0,        1, 2'd0);
        add(0, 8'h00, 0, 1, 0, 32'h0,        0, 2'd0);
        add(0, 8'h00, 0, 0, 0, 32'h0,        0, 2'd0);

        // reset state, held across clock edges
        tick();
        tick();
        chk("rst_valid",   {31'd0, word_vld}, 32'd0);
        chk("rst_word",    word_dat,          32'h0);
        chk("rst_ovf",     {31'd0, ovf},      32'd0);
        chk("rst_timeout", {31'd0, tmo},      32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            rx_dv    = tbl[i].dv;
            rx_byte  = tbl[i].b;
            word_rdy = tbl[i].rdy;
            clr      = tbl[i].clr;
            tick();
            chk($sformatf("vec%0d_valid", i), {31'd0, word_vld}, {31'd0, tbl[i].ev});
            chk($sformatf("vec%0d_ovf", i),   {31'd0, ovf},      {31'd0, tbl[i].eovf});
            chk($sformatf("vec%0d_count", i), {30'd0, dut.r_count}, {30'd0, tbl[i].ecnt});
            chk($sformatf("vec%0d_tmo", i),   {31'd0, tmo},      32'd0);
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_word", i), word_dat, tbl[i].ew);
            end
        end
        rx_dv = 1'b0; rx_byte = 8'h00; word_rdy = 1'b0; clr = 1'b0;

        // timeout: 2 bytes then 20 idle clocks
        send_byte(8'h5A);
        send_byte(8'hA5);
        to_cnt = 0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (tmo) to_cnt++;
            if (i == 20) chk("timeout_at_20", {31'd0, tmo}, 32'd1);
        end
        chk("timeout_pulses", to_cnt, 32'd1);
        chk("timeout_no_push", {31'd0, word_vld}, 32'd0);
        word_rdy = 1'b1;
        send_word(32'h04030201);
        chk("after_to_valid", {31'd0, word_vld}, 32'd1);
        chk("after_to_word",  word_dat,          32'h04030201);
        tick();
        chk("after_to_pop",   {31'd0, word_vld}, 32'd0);

        // byte lands exactly in the expiry cycle
        to_cnt = 0;
        send_byte(8'h11);
        for (int i = 1; i <= 19; i++) begin
            tick();
            if (tmo) to_cnt++;
        end
        send_byte(8'h22);
        if (tmo) to_cnt++;
        send_byte(8'h33);
        if (tmo) to_cnt++;
        send_byte(8'h44);
        if (tmo) to_cnt++;
        chk("race_valid", {31'd0, word_vld}, 32'd1);
        chk("race_word",  word_dat,          32'h44332211);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (tmo) to_cnt++;
        end
        chk("race_no_timeout", to_cnt, 32'd0);
        chk("race_drained", {31'd0, word_vld}, 32'd0);

        // full FIFO: push and pop in the same cycle
        word_rdy = 1'b0;
        send_word(32'hA4A3A2A1);
        send_word(32'hB4B3B2B1);
        chk("full_count", {30'd0, dut.r_count}, 32'd2);
        chk("full_head",  word_dat,             32'hA4A3A2A1);
        send_byte(8'hC1);
        send_byte(8'hC2);
        send_byte(8'hC3);
        word_rdy = 1'b1;
        send_byte(8'hC4);
        word_rdy = 1'b0;
        chk("pp_count", {30'd0, dut.r_count}, 32'd2);
        chk("pp_ovf",   {31'd0, ovf},         32'd0);
        chk("pp_head",  word_dat,             32'hB4B3B2B1);
        word_rdy = 1'b1;
        tick();
        chk("pp_next",  word_dat,             32'hC4C3C2C1);
        tick();
        chk("pp_empty", {31'd0, word_vld},    32'd0);
        word_rdy = 1'b0;

        // mid-word asynchronous reset with a queued word and overflow set
        send_word(32'h01020304);
        send_word(32'h05060708);
        send_word(32'h090A0B0C);
        chk("pre_rst_ovf", {31'd0, ovf}, 32'd1);
        send_byte(8'hE1);
        send_byte(8'hE2);
        send_byte(8'hE3);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, word_vld},    32'd0);
        chk("arst_word",  word_dat,             32'h0);
        chk("arst_ovf",   {31'd0, ovf},         32'd0);
        chk("arst_tmo",   {31'd0, tmo},         32'd0);
        chk("arst_idx",   {30'd0, dut.r_idx},   32'd0);
        chk("arst_count", {30'd0, dut.r_count}, 32'd0);
        tick();
        rst = 1'b0;
        chk("rst_hold_valid", {31'd0, word_vld}, 32'd0);
        word_rdy = 1'b1;
        send_word(32'hDDCCBBAA);
        chk("post_rst_valid", {31'd0, word_vld}, 32'd1);
        chk("post_rst_word",  word_dat,          32'hDDCCBBAA);
        tick();
        chk("post_rst_pop",   {31'd0, word_vld}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
